mem_arbiter: RTL and testbench

//  Shares the single byte-serial memory controller between instruction fetch (icache) and the

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-serial memory controller between instruction fetch and the load/store unit.
// Data requests win by default, and a streak counter keeps fetch from being starved.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [2:0]  ls_len,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [31:0] m_addr,
  output logic [2:0]  m_len,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic [2:0]  state_dbg
);

  // Handshake: a requester holds its req until its done pulse (or flush for fetch);
  // m_req is held with stable address/length/data until the cycle m_ack is sampled high.
  typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, DROP, DONE} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state;
  logic [CNT_W-1:0] streak;
  logic             pick_d;
  logic             pick_i;

  function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [2:0] len);
    case (len)
      3'd1:    mask_bytes = {24'd0, d[7:0]};
      3'd2:    mask_bytes = {16'd0, d[15:0]};
      default: mask_bytes = d;
    endcase
  endfunction

  // A flushed fetch request must not win, so flush lets data through even past the limit.
  always_comb begin
    pick_d = ls_req & (~if_req | (streak < LIMIT) | flush);
    pick_i = ~pick_d & if_req & ~flush;
  end

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      streak   <= '0;
      m_req    <= 1'b0;
      m_wr     <= 1'b0;
      m_addr   <= '0;
      m_len    <= '0;
      m_wdata  <= '0;
      if_valid <= 1'b0;
      if_data  <= '0;
      ls_done  <= 1'b0;
      ls_rdata <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state   <= GNT_D;
            m_req   <= 1'b1;
            m_addr  <= ls_addr;
            m_len   <= ls_len;
            m_wr    <= ls_wr;
            m_wdata <= ls_wdata;
            if (if_req)
              streak <= (streak >= LIMIT) ? LIMIT : streak + 1'b1;
            else
              streak <= '0;
          end else if (pick_i) begin
            state   <= GNT_I;
            m_req   <= 1'b1;
            m_addr  <= if_addr;
            m_len   <= 3'd4;
            m_wr    <= 1'b0;
            m_wdata <= '0;
            streak  <= '0;
          end
        end
        GNT_I: begin
          if (m_ack) begin
            m_req <= 1'b0;
            if (flush) begin
              state <= IDLE;
            end else begin
              if_data  <= m_rdata;
              if_valid <= 1'b1;
              state    <= DONE;
            end
          end else if (flush) begin
            state <= DROP;
          end
        end
        GNT_D: begin
          if (m_ack) begin
            m_req    <= 1'b0;
            ls_rdata <= m_wr ? '0 : mask_bytes(m_rdata, m_len);
            ls_done  <= 1'b1;
            state    <= DONE;
          end
        end
        DROP: begin
          // The controller cannot abort, so wait out the ack and discard the data.
          if (m_ack) begin
            m_req <= 1'b0;
            state <= IDLE;
          end
        end
        DONE: begin
          if_valid <= 1'b0;
          ls_done  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a rule-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_valid;
  logic [31:0] if_data;
  logic        ls_req = 1'b0;
  logic        ls_wr = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [2:0]  ls_len = 3'd4;
  logic [31:0] ls_wdata = '0;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        m_req;
  logic        m_wr;
  logic [31:0] m_addr;
  logic [2:0]  m_len;
  logic [31:0] m_wdata;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [2:0]  state_dbg;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_len(ls_len),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_len(m_len), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_req = 0; ls_req = 0; flush = 0; m_ack = 0; rdy = 1;
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
  endtask

  // driver tasks
  task automatic wait_mreq(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_req === 1'b1) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout: m_req got %b want 1 within 20 cycles", name, m_req);
    end
  endtask

  task automatic do_ack(input string name, input int delay, input logic [31:0] rdata);
    logic [31:0] a0;
    a0 = m_addr;
    repeat (delay) tick();
    checks++;
    if (m_req !== 1'b1 || m_addr !== a0) begin
      failures++;
      $display("FAIL %s_hold: m_req=%b m_addr=%h want 1/%h", name, m_req, m_addr, a0);
    end
    m_ack = 1;
    m_rdata = rdata;
    tick();
    m_ack = 0;
    m_rdata = $urandom;
  endtask

  function automatic logic [31:0] ref_mask(input logic [31:0] d, input int len);
    if (len == 1) return d % 256;
    if (len == 2) return d % 65536;
    return d;
  endfunction

  // scenarios
  task automatic test_reset();
    bit ok;
    ls_req = 1; ls_wr = 0; ls_addr = 32'h0000_5000; ls_len = 4;
    wait_mreq("rst_prep", ok);
    do_ack("rst_prep", 0, 32'hCAFE_F00D);
    ls_req = 0;
    tick();
    ls_req = 1; ls_wr = 1; ls_addr = 32'h0000_6004; ls_wdata = 32'h1234_5678; ls_len = 2;
    wait_mreq("rst_mid", ok);
    #2;
    rst = 1;
    #1;
    checks++;
    if ({m_req, m_wr, m_addr, m_len, m_wdata, if_valid, if_data, ls_done, ls_rdata, state_dbg} !== '0) begin
      failures++;
      $display("FAIL reset_async: m_req=%b m_addr=%h m_wdata=%h ls_rdata=%h want all 0",
               m_req, m_addr, m_wdata, ls_rdata);
    end
    ls_req = 0;
    tick();
    rst = 0;
    tick();
    checks++;
    if (m_req !== 1'b0 || ls_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: m_req=%b ls_done=%b want 0/0", m_req, ls_done);
    end
  endtask

  task automatic test_fetch();
    bit ok;
    do_reset();
    if_req = 1; if_addr = 32'h0000_1000;
    wait_mreq("fetch", ok);
    checks++;
    if (m_addr !== 32'h1000 || m_len !== 3'd4 || m_wr !== 1'b0 || m_wdata !== '0) begin
      failures++;
      $display("FAIL fetch_latch: addr=%h len=%0d wr=%b wdata=%h want 1000/4/0/0", m_addr, m_len, m_wr, m_wdata);
    end
    do_ack("fetch", 3, 32'h0000_0013);
    checks++;
    if (if_valid !== 1'b1 || if_data !== 32'h13 || m_req !== 1'b0 || ls_done !== 1'b0) begin
      failures++;
      $display("FAIL fetch_done: if_valid=%b if_data=%h m_req=%b want 1/13/0", if_valid, if_data, m_req);
    end
    if_req = 0;
    tick();
    checks++;
    if (if_valid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_pulse: if_valid=%b want 0", if_valid);
    end
  endtask

  task automatic test_priority();
    bit ok;
    do_reset();
    if_req = 1; if_addr = 32'h0000_1000;
    ls_req = 1; ls_wr = 0; ls_addr = 32'h0000_2000; ls_len = 2; ls_wdata = 32'h0;
    wait_mreq("prio_d", ok);
    checks++;
    if (m_addr !== 32'h2000 || m_len !== 3'd2 || m_wr !== 1'b0) begin
      failures++;
      $display("FAIL prio_first: addr=%h len=%0d wr=%b want 2000/2/0", m_addr, m_len, m_wr);
    end
    do_ack("prio_d", 1, 32'hDEAD_BEEF);
    checks++;
    if (ls_done !== 1'b1 || ls_rdata !== 32'h0000_BEEF || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL prio_load: ls_done=%b ls_rdata=%h want 1/0000beef", ls_done, ls_rdata);
    end
    ls_req = 0;
    wait_mreq("prio_i", ok);
    checks++;
    if (m_addr !== 32'h1000 || m_len !== 3'd4) begin
      failures++;
      $display("FAIL prio_second: addr=%h len=%0d want 1000/4", m_addr, m_len);
    end
    do_ack("prio_i", 0, 32'h0000_0093);
    checks++;
    if (if_valid !== 1'b1 || if_data !== 32'h93) begin
      failures++;
      $display("FAIL prio_fetch: if_valid=%b if_data=%h want 1/93", if_valid, if_data);
    end
    if_req = 0;
    tick();
  endtask

  task automatic test_starvation();
    bit ok;
    string got, want;
    do_reset();
    got = ""; want = "DDDDIDDDDI";
    if_req = 1; if_addr = 32'h0000_1000;
    ls_req = 1; ls_wr = 0; ls_len = 4;
    for (int k = 0; k < 10; k++) begin
      ls_addr = 32'h0000_2000 + k;
      wait_mreq("starve", ok);
      if (!ok) break;
      got = {got, (m_addr == 32'h1000) ? "I" : "D"};
      do_ack("starve", $urandom_range(0, 2), $urandom);
    end
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL starve_order: got %s want %s", got, want);
    end
    if_req = 0; ls_req = 0;
    tick();
  endtask

  task automatic test_flush_fetch();
    bit ok;
    int pulses;
    do_reset();
    if_req = 1; if_addr = 32'h0000_1000;
    wait_mreq("flush_i", ok);
    tick();
    tick();
    flush = 1;
    tick();
    flush = 0; if_req = 0;
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h1000) begin
      failures++;
      $display("FAIL flush_hold: m_req=%b m_addr=%h want 1/1000", m_req, m_addr);
    end
    pulses = 0;
    do_ack("flush_i", 2, 32'h1111_2222);
    for (int i = 0; i < 2; i++) begin
      if (if_valid === 1'b1) pulses++;
      if (i == 0) begin
        checks++;
        if (m_req !== 1'b0) begin
          failures++;
          $display("FAIL flush_release: m_req=%b want 0", m_req);
        end
        // DROP returns straight to IDLE, so a new fetch is granted on the next edge
        if_req = 1; if_addr = 32'h0000_1040;
      end
      tick();
      if (i == 0) begin
        checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h1040) begin
          failures++;
          $display("FAIL flush_regrant: m_req=%b m_addr=%h want 1/1040", m_req, m_addr);
        end
      end
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL flush_novalid: if_valid pulses %0d want 0", pulses);
    end
    // flush coincident with the ack drops the result and goes idle
    flush = 1;
    do_ack("flush_same", 1, 32'h3333_4444);
    flush = 0; if_req = 0;
    checks++;
    if (if_valid !== 1'b0 || m_req !== 1'b0) begin
      failures++;
      $display("FAIL flush_same: if_valid=%b m_req=%b want 0/0", if_valid, m_req);
    end
    ls_req = 1; ls_wr = 0; ls_addr = 32'h0000_7000; ls_len = 1;
    tick();
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h7000 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_same_idle: m_req=%b m_addr=%h if_valid=%b want 1/7000/0", m_req, m_addr, if_valid);
    end
    do_ack("flush_same_ls", 0, 32'h0000_00AB);
    ls_req = 0;
    tick();
  endtask

  task automatic test_store_flush();
    bit ok;
    int pulses;
    do_reset();
    ls_req = 1; ls_wr = 1; ls_addr = 32'h0003_0000; ls_len = 1; ls_wdata = 32'h41;
    wait_mreq("store", ok);
    tick();
    flush = 1;
    tick();
    flush = 0;
    checks++;
    if (m_req !== 1'b1 || m_wr !== 1'b1 || m_wdata !== 32'h41 || m_addr !== 32'h30000 || m_len !== 3'd1) begin
      failures++;
      $display("FAIL store_hold: req=%b wr=%b wdata=%h addr=%h len=%0d want 1/1/41/30000/1",
               m_req, m_wr, m_wdata, m_addr, m_len);
    end
    pulses = 0;
    do_ack("store", 1, 32'hFFFF_FFFF);
    checks++;
    if (ls_rdata !== 32'h0) begin
      failures++;
      $display("FAIL store_rdata: ls_rdata=%h want 0", ls_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      if (ls_done === 1'b1) pulses++;
      if (i == 0) ls_req = 0;
      tick();
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL store_done: ls_done pulses %0d want 1", pulses);
    end
  endtask

  task automatic test_rdy_freeze();
    bit ok;
    do_reset();
    ls_req = 1; ls_wr = 0; ls_addr = 32'h0000_4444; ls_len = 4;
    wait_mreq("freeze", ok);
    rdy = 0;
    m_ack = 1; m_rdata = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      m_ack = 0;
      checks++;
      if (m_req !== 1'b1 || m_addr !== 32'h4444 || ls_done !== 1'b0) begin
        failures++;
        $display("FAIL freeze_cyc%0d: m_req=%b m_addr=%h ls_done=%b want 1/4444/0", i, m_req, m_addr, ls_done);
      end
    end
    rdy = 1;
    do_ack("freeze", 1, 32'h1234_5678);
    checks++;
    if (ls_done !== 1'b1 || ls_rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL freeze_resume: ls_done=%b ls_rdata=%h want 1/12345678", ls_done, ls_rdata);
    end
    ls_req = 0;
    tick();
  endtask

  task automatic new_ls();
    int lens[4] = '{1, 2, 4, 3};
    ls_wr    = $urandom_range(0, 1);
    ls_addr  = $urandom;
    ls_len   = 3'(lens[$urandom_range(0, 3)]);
    ls_wdata = $urandom;
  endtask

  task automatic test_random();
    bit ok, ip, lp, exp_d;
    int streak_m;
    logic [31:0] rd;
    logic [31:0] exp_q[$];
    do_reset();
    ip = 0; lp = 0; streak_m = 0;
    for (int r = 0; r < 60; r++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; if_addr = $urandom; end
      if (!lp && $urandom_range(0, 3) != 0) begin lp = 1; new_ls(); end
      if (!ip && !lp) begin lp = 1; new_ls(); end
      if_req = ip; ls_req = lp;
      // data wins unless fetch is waiting and data already had its run of grants
      exp_d = lp && (!ip || streak_m < 4);
      exp_q.push_back(exp_d ? ls_addr : if_addr);
      wait_mreq("rand", ok);
      if (!ok) return;
      checks++;
      if (m_addr !== exp_q.pop_front() ||
          m_len !== (exp_d ? ls_len : 3'd4) ||
          m_wr !== (exp_d ? ls_wr : 1'b0) ||
          m_wdata !== (exp_d ? ls_wdata : 32'h0)) begin
        failures++;
        $display("FAIL rand_grant%0d: addr=%h len=%0d wr=%b wdata=%h data_expected=%b",
                 r, m_addr, m_len, m_wr, m_wdata, exp_d);
      end
      if (exp_d) streak_m = ip ? ((streak_m + 1 > 4) ? 4 : streak_m + 1) : 0;
      else streak_m = 0;
      rd = $urandom;
      do_ack("rand", $urandom_range(0, 3), rd);
      checks++;
      if (exp_d) begin
        if (ls_done !== 1'b1 || if_valid !== 1'b0 || ls_rdata !== (ls_wr ? 32'h0 : ref_mask(rd, int'(ls_len)))) begin
          failures++;
          $display("FAIL rand_ls%0d: ls_done=%b if_valid=%b ls_rdata=%h want 1/0/%h",
                   r, ls_done, if_valid, ls_rdata, ls_wr ? 32'h0 : ref_mask(rd, int'(ls_len)));
        end
        lp = 0; ls_req = 0;
      end else begin
        if (if_valid !== 1'b1 || ls_done !== 1'b0 || if_data !== rd) begin
          failures++;
          $display("FAIL rand_if%0d: if_valid=%b ls_done=%b if_data=%h want 1/0/%h",
                   r, if_valid, ls_done, if_data, rd);
        end
        ip = 0; if_req = 0;
      end
      tick();
      checks++;
      if (if_valid !== 1'b0 || ls_done !== 1'b0 || m_req !== 1'b0) begin
        failures++;
        $display("FAIL rand_gap%0d: if_valid=%b ls_done=%b m_req=%b want 0/0/0", r, if_valid, ls_done, m_req);
      end
    end
    if_req = 0; ls_req = 0;
    tick();
  endtask

  // sequence and final report
  initial begin
    do_reset();
    checks++;
    if ({m_req, m_wr, m_addr, m_len, m_wdata, if_valid, if_data, ls_done, ls_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_state: m_req=%b m_addr=%h if_valid=%b ls_done=%b want all 0",
               m_req, m_addr, if_valid, ls_done);
    end
    test_reset();
    test_fetch();
    test_priority();
    test_starvation();
    test_flush_fetch();
    test_store_flush();
    test_rdy_freeze();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
